// File: rtl/sram_port_pkg.sv
`default_nettype none
// ============================================================================
// sram_port_pkg : shared FSM state type and limits for sram_port_initiator
// Revision 1.0
// ============================================================================
package sram_port_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Smallest legal response FIFO depth
  localparam int RSP_DEPTH_MIN = 3;

endpackage
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// sram_rsp_fifo : synchronous response FIFO with occupancy count
// Revision 1.0
// ============================================================================
module sram_rsp_fifo #(
  parameter int DATA_WIDTH = 2,
  parameter int RSP_DEPTH  = 4,
  parameter int CNT_WIDTH  = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PTR_WIDTH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
  assign do_pop     = pop && head_valid;
  assign do_push    = push && ((count != CNT_WIDTH'(RSP_DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_WIDTH'(RSP_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/sram_port_initiator.sv
`default_nettype none
// ============================================================================
// sram_port_initiator : valid/ready front end for a 1RW OpenRAM SRAM port
// Revision 1.0
// ============================================================================
module sram_port_initiator
  import sram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CNT_WIDTH = $clog2(RSP_DEPTH + 1);
  localparam int SUM_WIDTH = CNT_WIDTH + 1;

  if (RSP_DEPTH < RSP_DEPTH_MIN) begin : g_depth_check
    $error("sram_port_initiator: RSP_DEPTH must be at least %0d", RSP_DEPTH_MIN);
  end

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;
  logic                  tag1, tag2;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic [SUM_WIDTH-1:0]  credit_used;
  logic                  accept;
  logic                  issue, issue_we, issue_read;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_din;

  // Every read that is in the tag pipe or the FIFO holds one FIFO credit
  assign credit_used = SUM_WIDTH'(fifo_count) + SUM_WIDTH'(tag1) + SUM_WIDTH'(tag2);
  assign req_ready   = init_done && (credit_used < SUM_WIDTH'(RSP_DEPTH));
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    issue        = 1'b0;
    issue_we     = 1'b0;
    issue_read   = 1'b0;
    issue_addr   = addr0;
    issue_din    = din0;
    case (state)
      CLEAR: begin
        issue        = 1'b1;
        issue_we     = 1'b1;
        issue_addr   = clr_addr;
        issue_din    = '0;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == '1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          issue      = 1'b1;
          issue_we   = req_we;
          issue_read = !req_we;
          issue_addr = req_addr;
          if (req_we) begin
            issue_din = req_wdata;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state    <= (INIT_CLEAR != 0) ? CLEAR : RUN;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      csb0      <= 1'b1;
      web0      <= 1'b1;
      addr0     <= '0;
      din0      <= '0;
      init_done <= 1'b0;
      tag1      <= 1'b0;
      tag2      <= 1'b0;
    end else begin
      csb0      <= !issue;
      web0      <= !issue_we;
      addr0     <= issue_addr;
      din0      <= issue_din;
      // Lags entry to RUN by one cycle, which also idles the port after the sweep
      init_done <= init_done || (state == RUN);
      tag1      <= issue_read;
      tag2      <= tag1;
    end
  end

  sram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_rsp_fifo (
    .clk        (clk0),
    .rst_n      (rst0_n),
    .push       (tag2),
    .push_data  (dout0),
    .pop        (rsp_ready),
    .head_data  (rsp_rdata),
    .head_valid (rsp_valid),
    .count      (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_port_initiator.sv
`default_nettype none
// ============================================================================
// tb_sram_port_initiator : self-checking bench with SRAM model and scoreboard
// Revision 1.0
// ============================================================================
module tb_sram_port_initiator;

  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int RD    = 4;

  logic          clk0 = 1'b0;
  logic          rst0_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0 = '0;

  int tests = 0;
  int fails = 0;

  sram_port_initiator #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (RD),
    .INIT_CLEAR (1)
  ) dut (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .csb0      (csb0),
    .web0      (web0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  always #5 clk0 = ~clk0;

  // SRAM macro: samples controls on the rising edge, drives dout0 after the falling edge
  logic [DW-1:0] sram [DEPTH];
  logic          cs_l = 1'b1;
  logic          rd_l = 1'b0;
  logic [AW-1:0] a_l  = '0;

  always @(posedge clk0) begin
    cs_l <= csb0;
    rd_l <= web0;
    a_l  <= addr0;
    if (!csb0 && !web0) sram[addr0] <= din0;
  end

  always @(negedge clk0) begin
    if (!cs_l && rd_l) dout0 <= sram[a_l];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents in program order and expected responses in order
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic          rdy_chk   = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk0) begin
    if (!rst0_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (rdy_chk) check("req_ready_credit", req_ready, (exp_q.size() < RD));
      if (prev_hold) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_data", rsp_rdata, prev_data);
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_rdata;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else check("rsp_order_data", rsp_rdata, exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   n;
    int   acc;

    for (int i = 0; i < DEPTH; i++) tbl.push_back('{1'b0, AW'(i), DW'(0), DW'(0)});
    tbl.push_back('{1'b1, AW'(5), 2'b10, 2'b00});
    tbl.push_back('{1'b0, AW'(5), 2'b00, 2'b10});
    for (int i = 0; i < DEPTH; i++) tbl.push_back('{1'b1, AW'(i), DW'(i & 3), DW'(0)});
    for (int i = 0; i < DEPTH; i++) tbl.push_back('{1'b0, AW'(i), DW'(0), DW'(i & 3)});
    n = tbl.size();

    // Reset values
    repeat (2) @(posedge clk0);
    @(negedge clk0);
    check("rst_csb0", csb0, 1);
    check("rst_web0", web0, 1);
    check("rst_addr0", addr0, 0);
    check("rst_din0", din0, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);

    // Clear sweep
    @(posedge clk0); #1 rst0_n = 1'b1;
    @(posedge clk0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk0);
      check("sweep_csb0", csb0, 0);
      check("sweep_web0", web0, 0);
      check("sweep_din0", din0, 0);
      check("sweep_addr0", addr0, i);
    end
    @(negedge clk0);
    check("post_sweep_csb0", csb0, 1);
    check("post_sweep_init_done", init_done, 1);
    check("post_sweep_req_ready", req_ready, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rdy_chk = 1'b1;

    // Table vectors, one per cycle; reads answer exactly 2 cycles after acceptance
    for (int j = 0; j < n + 3; j++) begin
      @(posedge clk0); #1;
      if (j < n) begin
        req_valid = 1'b1;
        req_we    = tbl[j].we;
        req_addr  = tbl[j].addr;
        req_wdata = tbl[j].wdata;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk0);
      if (j < n) check("tbl_req_ready", req_ready, 1);
      if (j >= 3) begin
        if (tbl[j-3].we) begin
          check("tbl_no_rsp_for_write", rsp_valid, 0);
        end else begin
          check("tbl_rsp_valid", rsp_valid, 1);
          check("tbl_rsp_data", rsp_rdata, tbl[j-3].exp);
        end
      end
    end

    // Backpressure: exactly RD reads accepted, then in-order drain
    @(posedge clk0); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = '0;
    acc       = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk0);
      if (req_ready) acc++;
      @(posedge clk0); #1;
      req_addr = AW'(acc);
    end
    req_valid = 1'b0;
    check("bp_accepted", acc, RD);
    repeat (2) @(posedge clk0);
    #1 rsp_ready = 1'b1;
    @(negedge clk0);
    check("bp_ready_low_full", req_ready, 0);
    check("bp_head0", rsp_rdata, 0);
    @(negedge clk0);
    check("bp_ready_after_pop", req_ready, 1);
    check("bp_head1", rsp_rdata, 1);
    @(negedge clk0);
    check("bp_head2", rsp_rdata, 2);
    @(negedge clk0);
    check("bp_head3", rsp_rdata, 3);
    @(negedge clk0);
    check("bp_empty", rsp_valid, 0);

    // Random traffic with read bursts against a throttled consumer
    for (int c = 0; c < 800; c++) begin
      @(posedge clk0); #1;
      if ((c % 100) < 30) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = ($urandom_range(0, 2) == 0);
        rsp_ready = ($urandom_range(0, 2) != 0);
      end
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = DW'($urandom);
    end
    @(posedge clk0); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk0);
      if (exp_q.size() == 0 && !rsp_valid) break;
    end
    check("drain_outstanding", exp_q.size(), 0);
    check("drain_rsp_valid", rsp_valid, 0);

    // Reset in the middle of the sweep
    rdy_chk = 1'b0;
    @(posedge clk0); #1 rst0_n = 1'b0;
    repeat (2) @(posedge clk0);
    #1 rst0_n = 1'b1;
    @(posedge clk0);
    for (int i = 0; i < 8; i++) @(negedge clk0);
    check("mid_addr7", addr0, 7);
    check("mid_csb0_active", csb0, 0);
    #2 rst0_n = 1'b0;
    #1;
    check("mid_async_csb0", csb0, 1);
    check("mid_async_init_done", init_done, 0);
    check("mid_async_addr0", addr0, 0);
    @(posedge clk0);
    @(posedge clk0); #1 rst0_n = 1'b1;
    @(posedge clk0);
    @(negedge clk0);
    check("restart_addr0", addr0, 0);
    check("restart_csb0", csb0, 0);
    @(negedge clk0);
    check("restart_addr1", addr0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
